crc_check: RTL and testbench

- Receive-path counterpart of the team's CRC appender.
- Consumes a serial bitstream of payload followed by the inverted CRC (CRC5 for tokens, CRC16 for data), runs the same LFSR over every bit, and checks the residual at end of packet.
- Optionally strips the CRC field so downstream sees payload bits only.
- Sits between the bit unstuffer and the packet deserializer.

---
 rtl/crc_pkg.sv | 13 +
 rtl/crc_lfsr.sv | 28 ++
 rtl/crc_check.sv | 156 +++++++++++++++
 tb/tb_crc_check.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/crc_pkg.sv
// Shared state encoding and CRC constants for the receive-path CRC checker.
package crc_pkg;

    typedef enum logic [1:0] {IDLE, RECV, CHECK} state_t;

    localparam logic [4:0]  CRC5_POLY   = 5'b00101;
    localparam logic [15:0] CRC16_POLY  = 16'h8005;
    localparam logic [4:0]  CRC5_RESID  = 5'b01100;
    localparam logic [15:0] CRC16_RESID = 16'h800D;
    localparam int          CRC5_LEN    = 5;
    localparam int          CRC16_LEN   = 16;

endpackage

// File: rtl/crc_lfsr.sv
// Serial CRC LFSR, MSB is the highest-order term; data enters at the top.
module crc_lfsr #(
    parameter int                 WIDTH = 5,
    parameter logic [WIDTH-1:0]   POLY  = '0
) (
    input  logic             clk,
    input  logic             rst_L,
    input  logic             init,
    input  logic             shift,
    input  logic             inb,
    output logic [WIDTH-1:0] Q
);

    logic fb;

    assign fb = inb ^ Q[WIDTH-1];

    always_ff @(posedge clk or negedge rst_L) begin
        if (!rst_L) begin
            Q <= '1;
        end else if (init) begin
            Q <= '1;
        end else if (shift) begin
            Q <= {Q[WIDTH-2:0], 1'b0} ^ (fb ? POLY : '0);
        end
    end

endmodule

// File: rtl/crc_check.sv
// Receive-side CRC5/CRC16 residual checker between bit unstuffer and deserializer.
// Define CRC_STRIP_EN to drop the CRC field from the outb stream.
module crc_check
    import crc_pkg::*;
#(
    parameter int MAXCRC = 16
) (
    input  logic clk,
    input  logic rst_L,
    input  logic clear,
    input  logic start,
    input  logic pkttype,
    input  logic recving,
    input  logic pause_in,
    input  logic inb,
    output logic outb,
    output logic out_valid,
    output logic done,
    output logic crc_ok,
    output logic crc_err,
    output logic len_err
);

    state_t      state_q, state_d;
    logic        crctype_q, crctype_d;
    logic [4:0]  cnt_q, cnt_d;
    logic        ok_q, ok_d;
    logic        err_q, err_d;
    logic        len_q, len_d;
    logic [4:0]  lfsr5_q;
    logic [15:0] lfsr16_q;
    logic        take;
    logic        lfsr_init;
    logic [4:0]  crc_len;
    logic        short_pkt;
    logic        resid_ok;

    if (MAXCRC < CRC16_LEN) begin : g_bad_depth
        $error("crc_check: MAXCRC must be at least 16");
    end

    // A bit is taken in RECV, or in the IDLE cycle that opens the packet.
    assign take      = ~clear & recving & ~pause_in &
                       ((state_q == RECV) | ((state_q == IDLE) & ~start));
    assign lfsr_init = clear | ((state_q == IDLE) & start);
    assign crc_len   = crctype_q ? 5'(CRC16_LEN) : 5'(CRC5_LEN);
    assign short_pkt = cnt_q < crc_len;
    assign resid_ok  = crctype_q ? (lfsr16_q == CRC16_RESID) : (lfsr5_q == CRC5_RESID);

    crc_lfsr #(.WIDTH(5), .POLY(CRC5_POLY)) u_lfsr5 (
        .clk   (clk),
        .rst_L (rst_L),
        .init  (lfsr_init),
        .shift (take),
        .inb   (inb),
        .Q     (lfsr5_q)
    );

    crc_lfsr #(.WIDTH(16), .POLY(CRC16_POLY)) u_lfsr16 (
        .clk   (clk),
        .rst_L (rst_L),
        .init  (lfsr_init),
        .shift (take),
        .inb   (inb),
        .Q     (lfsr16_q)
    );

    always_comb begin
        state_d   = state_q;
        crctype_d = crctype_q;
        cnt_d     = cnt_q;
        ok_d      = ok_q;
        err_d     = err_q;
        len_d     = len_q;
        if (clear) begin
            state_d = IDLE;
            cnt_d   = '0;
            ok_d    = 1'b0;
            err_d   = 1'b0;
            len_d   = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        crctype_d = pkttype;
                        cnt_d     = '0;
                        ok_d      = 1'b0;
                        err_d     = 1'b0;
                        len_d     = 1'b0;
                    end else if (recving) begin
                        state_d = RECV;
                    end
                end
                RECV: begin
                    // Result is registered on the way into CHECK so it lines up with done.
                    if (!recving) begin
                        state_d = CHECK;
                        len_d   = short_pkt;
                        ok_d    = ~short_pkt & resid_ok;
                        err_d   = short_pkt | ~resid_ok;
                    end
                end
                CHECK:   state_d = IDLE;
                default: state_d = IDLE;
            endcase
            if (take && cnt_q != 5'd31) begin
                cnt_d = cnt_q + 5'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_L) begin
        if (!rst_L) begin
            state_q   <= IDLE;
            crctype_q <= 1'b0;
            cnt_q     <= '0;
            ok_q      <= 1'b0;
            err_q     <= 1'b0;
            len_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            crctype_q <= crctype_d;
            cnt_q     <= cnt_d;
            ok_q      <= ok_d;
            err_q     <= err_d;
            len_q     <= len_d;
        end
    end

    assign done    = (state_q == CHECK);
    assign crc_ok  = ok_q;
    assign crc_err = err_q;
    assign len_err = len_q;

`ifdef CRC_STRIP_EN
    logic [MAXCRC-1:0] dl_q;

    always_ff @(posedge clk or negedge rst_L) begin
        if (!rst_L) begin
            dl_q <= '0;
        end else if (clear || state_q == CHECK) begin
            dl_q <= '0;
        end else if (take) begin
            dl_q <= {dl_q[MAXCRC-2:0], inb};
        end
    end

    // The tap N-1 holds the bit that now has N newer bits behind it.
    assign outb      = crctype_q ? dl_q[CRC16_LEN-1] : dl_q[CRC5_LEN-1];
    assign out_valid = take & (cnt_q >= crc_len);
`else
    assign outb      = inb;
    assign out_valid = take;
`endif

endmodule

// File: tb/tb_crc_check.sv
// Scoreboard bench for crc_check: random and directed packets against a polynomial-division CRC model.
module tb_crc_check;

    logic clk = 1'b0;
    logic rst_L = 1'b0;
    logic clear = 1'b0;
    logic start = 1'b0;
    logic pkttype = 1'b0;
    logic recving = 1'b0;
    logic pause_in = 1'b0;
    logic inb = 1'b0;
    logic outb, out_valid, done, crc_ok, crc_err, len_err;

    crc_check dut (
        .clk       (clk),
        .rst_L     (rst_L),
        .clear     (clear),
        .start     (start),
        .pkttype   (pkttype),
        .recving   (recving),
        .pause_in  (pause_in),
        .inb       (inb),
        .outb      (outb),
        .out_valid (out_valid),
        .done      (done),
        .crc_ok    (crc_ok),
        .crc_err   (crc_err),
        .len_err   (len_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        bit ok;
        bit err;
        bit len;
        int cyc;
    } res_t;

    res_t res_q[$];
    bit   bit_q[$];
    bit   pkt[$];
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // CRC as remainder of (M(x)*x^N + ones*x^len) mod G(x); the ones term models the all-ones preset.
    function automatic logic [15:0] model_crc(input bit m[$], input bit t16);
        int        n;
        bit [16:0] gp;
        bit        a[$];
        logic [15:0] r;
        n  = t16 ? 16 : 5;
        gp = t16 ? 17'h18005 : 17'h00025;
        a  = m;
        for (int i = 0; i < n; i++) a.push_back(1'b0);
        for (int i = 0; i < n; i++) a[i] = ~a[i];
        for (int i = 0; i < a.size() - n; i++) begin
            if (a[i]) begin
                for (int k = 0; k <= n; k++) a[i+k] = a[i+k] ^ gp[n-k];
            end
        end
        r = '0;
        for (int k = 0; k < n; k++) r[n-1-k] = a[a.size()-n+k];
        return r;
    endfunction

    task automatic make_pkt(input logic [63:0] val, input int len, input bit t16, input int flip);
        bit          pl[$];
        logic [15:0] c;
        int          n;
        n = t16 ? 16 : 5;
        for (int i = len - 1; i >= 0; i--) pl.push_back(val[i]);
        c   = model_crc(pl, t16);
        pkt = pl;
        for (int j = n - 1; j >= 0; j--) pkt.push_back(~c[j]);
        if (flip >= 0) pkt[flip] = ~pkt[flip];
    endtask

    // pmode: 0 no stalls, 1 stall every third cycle, 2 random stalls.
    task automatic send(input bit t16, input int pmode, input int abort_at, input bit do_reset);
        int          n, consumed, emit, idx, pc;
        bit          pause;
        bit          payload[$];
        logic [15:0] c;
        bit          good;
        res_t        r;
        n        = t16 ? 16 : 5;
        consumed = (abort_at >= 0) ? abort_at : pkt.size();
`ifdef CRC_STRIP_EN
        emit = consumed - n;
`else
        emit = consumed;
`endif
        for (int i = 0; i < emit; i++) bit_q.push_back(pkt[i]);

        @(posedge clk); #1;
        start = 1'b1; pkttype = t16; recving = 1'b0; pause_in = 1'b0; clear = 1'b0;
        @(posedge clk); #1;
        start = 1'b0;
        idx = 0;
        pc  = 0;
        while (idx < pkt.size() && idx != abort_at) begin
            case (pmode)
                1:       pause = (pc % 3 == 2);
                2:       pause = ($urandom_range(3) == 0);
                default: pause = 1'b0;
            endcase
            recving  = 1'b1;
            pause_in = pause;
            inb      = pause ? 1'($urandom) : pkt[idx];
            if (!pause) idx++;
            pc++;
            @(posedge clk); #1;
        end

        if (abort_at >= 0 && !do_reset) begin
            recving = 1'b1; pause_in = 1'b0; inb = pkt[idx]; clear = 1'b1;
            @(posedge clk); #1;
            clear = 1'b0; recving = 1'b0;
            chk("abort_done", 32'(done), 0);
            chk("abort_ok", 32'(crc_ok), 0);
            chk("abort_err", 32'(crc_err), 0);
            chk("abort_len", 32'(len_err), 0);
            repeat (3) begin @(posedge clk); #1; end
        end else if (abort_at >= 0) begin
            recving = 1'b1; pause_in = 1'b0; inb = pkt[idx];
            #3;
            rst_L = 1'b0; recving = 1'b0; inb = 1'b0;
            #1;
            chk("rst_done", 32'(done), 0);
            chk("rst_ok", 32'(crc_ok), 0);
            chk("rst_err", 32'(crc_err), 0);
            chk("rst_len", 32'(len_err), 0);
            chk("rst_valid", 32'(out_valid), 0);
            chk("rst_outb", 32'(outb), 0);
            @(posedge clk); #1;
            rst_L = 1'b1;
            repeat (2) begin @(posedge clk); #1; end
        end else begin
            if (pkt.size() < n) begin
                r = '{ok: 1'b0, err: 1'b1, len: 1'b1, cyc: cyc + 1};
            end else begin
                payload = pkt[0:pkt.size()-n-1];
                c       = model_crc(payload, t16);
                good    = 1'b1;
                for (int j = 0; j < n; j++) begin
                    if (pkt[pkt.size()-n+j] != ~c[n-1-j]) good = 1'b0;
                end
                r = '{ok: good, err: !good, len: 1'b0, cyc: cyc + 1};
            end
            res_q.push_back(r);
            recving = 1'b0; pause_in = 1'b0; inb = 1'b0;
            repeat (3) begin @(posedge clk); #1; end
        end
    endtask

    res_t mr;
    bit   mb;
    always @(negedge clk) begin
        if (rst_L) begin
            if (out_valid) begin
                if (bit_q.size() == 0) begin
                    chk("outb_unexpected", 32'(out_valid), 0);
                end else begin
                    mb = bit_q.pop_front();
                    chk("outb", 32'(outb), 32'(mb));
                end
            end
            if (done) begin
                if (res_q.size() == 0) begin
                    chk("done_unexpected", 32'(done), 0);
                end else begin
                    mr = res_q.pop_front();
                    chk("crc_ok", 32'(crc_ok), 32'(mr.ok));
                    chk("crc_err", 32'(crc_err), 32'(mr.err));
                    chk("len_err", 32'(len_err), 32'(mr.len));
                    chk("done_cycle", 32'(cyc), 32'(mr.cyc));
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, cycle %0d", cyc);
        $fatal(1, "timeout");
    end

    initial begin
        logic [63:0] rv;
        int          t16, n, len, flip;

        #12;
        chk("reset_done", 32'(done), 0);
        chk("reset_ok", 32'(crc_ok), 0);
        chk("reset_err", 32'(crc_err), 0);
        chk("reset_len", 32'(len_err), 0);
        chk("reset_valid", 32'(out_valid), 0);
        @(posedge clk); #1;
        rst_L = 1'b1;

        make_pkt(64'h0, 11, 1'b0, -1);
        send(1'b0, 0, -1, 1'b0);

        make_pkt(64'h0123456789ABCDEF, 64, 1'b1, -1);
        send(1'b1, 1, -1, 1'b0);

        make_pkt(64'h0123456789ABCDEF, 64, 1'b1, 10);
        send(1'b1, 0, -1, 1'b0);

        pkt.delete();
        pkt.push_back(1'b1); pkt.push_back(1'b0); pkt.push_back(1'b1);
        send(1'b1, 0, -1, 1'b0);
        chk("err_held", 32'(crc_err), 1);
        clear = 1'b1;
        @(posedge clk); #1;
        clear = 1'b0;
        chk("clear_err", 32'(crc_err), 0);
        chk("clear_len", 32'(len_err), 0);

        rv = {$urandom, $urandom};
        make_pkt(rv, 11, 1'b0, -1);
        send(1'b0, 0, 7, 1'b0);
        make_pkt(rv, 11, 1'b0, -1);
        send(1'b0, 2, -1, 1'b0);

        rv = {$urandom, $urandom};
        make_pkt(rv, 40, 1'b1, -1);
        send(1'b1, 0, 20, 1'b1);
        make_pkt(rv, 40, 1'b1, -1);
        send(1'b1, 2, -1, 1'b0);

        for (int p = 0; p < 8; p++) begin
            t16  = $urandom_range(1);
            n    = (t16 != 0) ? 16 : 5;
            len  = $urandom_range(40, 1);
            flip = ($urandom_range(1) != 0) ? $urandom_range(len + n - 1) : -1;
            rv   = {$urandom, $urandom};
            make_pkt(rv, len, t16[0], flip);
            send(t16[0], 2, -1, 1'b0);
        end

        repeat (5) begin @(posedge clk); #1; end
        chk("scoreboard_drained", 32'(res_q.size() + bit_q.size()), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
